yqc_seg_scan: RTL and testbench
===============================

// Module: yqc_seg_scan
// PURPOSE
//   Display stage downstream of the yqc_jisuanqi calculator core: captures its 8-bit result.
//   Converts the result to BCD with a sequential double-dabble (shift-and-add-3) engine.
//   Time-multiplexes the value, plus an optional minus sign, onto a 4-digit common-anode 7-segment display.
//   A result pulse mid-conversion is buffered one-deep (last value wins); the display never shows a half-converted value.
// PARAMETERS
//   SCAN_DIV  100000  clk cycles each digit is lit (1 kHz/digit at 100 MHz); legal range >= 2
//   DATA_W    8       result width; fixed at 8 (max 255 -> 3 BCD digits)
// PORTS
//   clk         in   1  system clock, single clock domain
//   rst         in   1  synchronous, active-high reset
//   data_in     in   8  unsigned magnitude of calculator result
//   data_neg    in   1  sign of result, sampled with data_in (1 = show '-')
//   data_valid  in   1  one-cycle strobe: data_in/data_neg are valid this cycle
//   seg         out  8  segments, active-low: [7]=dp, [6:0]=g..a
//   dig         out  4  digit enables, active-low one-hot: [0]=ones ... [3]=sign
//   busy        out  1  conversion in progress (CONVERT or COMMIT state)
// BEHAVIOUR
//   Reset (rst sampled high at a clk edge):
//     seg=8'hFF, dig=4'hF, busy=0.
//     Display register = 0 (renders "   0"); pending buffer empty; FSM=IDLE.
//     Scan counter and digit index = 0.
//     A conversion in progress is abandoned.
//   FSM states and transitions:
//     IDLE -> CONVERT on data_valid; loads shift reg {12'b0, data_in}, latches data_neg, sets iter=0.
//     CONVERT: each cycle, add 3 to every BCD nibble >= 5, then shift left by 1; iter++.
//       After 8 iterations, go to COMMIT.
//     COMMIT: copy BCD and sign into the display register.
//       If pending is full: go to CONVERT with the pending value and clear pending.
//       Otherwise go to IDLE.
//   Latency:
//     data_valid sampled at edge t; CONVERT occupies edges t+1..t+8; COMMIT at edge t+9.
//     The new value is displayed from the cycle after edge t+9.
//   busy: 1 from edge t through edge t+9 (exclusive of IDLE).
//   data_valid while busy:
//     Written to pending (overwrites any earlier pending value).
//     A data_valid in the same cycle as COMMIT also goes to pending and is converted next.
//   Rendering, per digit index k:
//     k0 = ones digit, always shown.
//     k1 = tens digit; blank if hundreds==0 and tens==0.
//     k2 = hundreds digit; blank if 0.
//     k3 = '-' (seg=8'hBF) if sign is set, else blank (8'hFF).
//     dp is always off (seg[7]=1).
//     Digit codes (seg[6:0]):
//       0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//   Scan timing:
//     Divider counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the index advances 0->1->2->3->0.
//     dig = ~(4'b1 << index); seg follows the same index.
//     Both outputs are registered and change on the same edge, so there is no ghosting.
//   Scan and conversion are independent; a display-register update takes effect on the digit currently lit.
// STRUCTURE
//   Package yqc_pkg:
//     state enum (IDLE/CONVERT/COMMIT).
//     SEG_DIGIT[0:9], SEG_BLANK=8'hFF, SEG_MINUS=8'hBF.
//   Sub-module yqc_bin2bcd:
//     Sequential double-dabble with start/done handshake and a 4-bit iteration counter.
//     Output bcd[11:0].
//   Top level holds the FSM, pending buffer, display register, scan divider and segment mux.
// TESTING  (bench uses SCAN_DIV=4)
//   1. Reset held 2 cycles -> seg=FF, dig=F, busy=0.
//      After release, dig cycles E,D,B,7 every 4 clks; ones digit seg=C0; other digits FF.
//   2. data_in=8 (3+5), data_valid pulse at t -> busy high t..t+9.
//      From t+10: ones=80, tens/hund/sign blank.
//   3. data_in=255, data_neg=1 -> digits 2,5,5 show A4,92,92; sign digit shows BF.
//   4. data_in=100 -> ones=C0, tens=C0 (not blanked), hundreds=F9.
//   5. Pulse data_valid with 12, then 3 and 6 two and four cycles later -> 12 displays at t+10.
//      Then 6 displays at t+20; 3 never appears.
//   6. rst asserted at t+4 of a conversion of 77 -> display returns to "   0", busy=0.
//      No 77 appears afterwards.

Source files
------------

// File: rtl/yqc_pkg.sv
// Shared types and constants for the yqc_seg_scan display stage.
package yqc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  // Double-dabble step count equals the binary input width.
  localparam logic [3:0] ITER_N = 4'd8;

  // Active-low segment codes, dp (bit 7) off.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Segment pattern for one BCD nibble; non-decimal codes render blank.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] r;
    r = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) r = SEG_DIGIT[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/yqc_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits in 8 cycles.
// done is high during the final shift cycle, so bcd is valid from the next cycle.
module yqc_bin2bcd
  import yqc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  // [19:8] BCD digits, [7:0] binary bits still to be shifted in.
  logic [19:0] r_shift;
  logic [3:0]  r_iter;
  logic [19:0] w_adj;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_adj = r_shift;
    for (int n = 0; n < 3; n++) begin
      if (r_shift[8 + 4*n +: 4] >= 4'd5)
        w_adj[8 + 4*n +: 4] = r_shift[8 + 4*n +: 4] + 4'd3;
    end
  end

  // Load on start, otherwise shift until ITER_N steps are done.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_shift <= '0;
      r_iter  <= ITER_N;
    end else if (start) begin
      r_shift <= {12'b0, bin};
      r_iter  <= 4'd0;
    end else if (r_iter != ITER_N) begin
      r_shift <= {w_adj[18:0], 1'b0};
      r_iter  <= r_iter + 4'd1;
    end
  end

  assign bcd  = r_shift[19:8];
  assign done = (r_iter == ITER_N - 4'd1);

endmodule

// File: rtl/yqc_seg_scan.sv
// Captures calculator results, converts them to BCD and scans them onto a
// 4-digit common-anode display (sign, hundreds, tens, ones).
module yqc_seg_scan
  import yqc_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DATA_W   = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_neg,
  input  logic              data_valid,
  output logic [7:0]        seg,
  output logic [3:0]        dig,
  output logic              busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e       r_state, w_state_nxt;
  logic [7:0]   r_pend_data;
  logic         r_pend_neg, r_pend_full;
  logic         r_conv_neg;
  logic [11:0]  r_disp_bcd;
  logic         r_disp_neg;
  logic [DIV_W-1:0] r_div;
  logic [1:0]   r_idx;
  logic [7:0]   r_seg;
  logic [3:0]   r_dig;

  logic         w_start, w_start_neg, w_commit, w_done;
  logic [7:0]   w_start_data;
  logic [11:0]  w_bcd, w_disp_bcd_nxt;
  logic         w_disp_neg_nxt;
  logic [7:0]   w_seg_nxt;

  yqc_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (w_start_data),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  // Next-state and conversion-start decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_data = data_in;
    w_start_neg  = data_neg;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (w_done) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        // A strobe arriving now is newer than anything pending, so it wins.
        if (data_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CONVERT;
        end else if (r_pend_full) begin
          w_start      = 1'b1;
          w_start_data = r_pend_data;
          w_start_neg  = r_pend_neg;
          w_state_nxt  = ST_CONVERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and the sign travelling with the conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_conv_neg <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) r_conv_neg <= w_start_neg;
    end
  end

  // One-deep pending buffer; last strobe during a conversion wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      r_pend_data <= '0;
      r_pend_neg  <= 1'b0;
    end else if (r_state == ST_CONVERT && data_valid) begin
      r_pend_full <= 1'b1;
      r_pend_data <= data_in;
      r_pend_neg  <= data_neg;
    end else if (r_state == ST_COMMIT) begin
      r_pend_full <= 1'b0;
    end
  end

  // Display register only ever receives a finished conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
    end else if (w_commit) begin
      r_disp_bcd <= w_bcd;
      r_disp_neg <= r_conv_neg;
    end
  end

  assign w_disp_bcd_nxt = w_commit ? w_bcd      : r_disp_bcd;
  assign w_disp_neg_nxt = w_commit ? r_conv_neg : r_disp_neg;

  // Scan divider and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Segment pattern for the selected digit, with leading-zero blanking.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (r_idx)
      2'd0: w_seg_nxt = seg_of(w_disp_bcd_nxt[3:0]);
      2'd1: if (w_disp_bcd_nxt[11:4] != 8'd0) w_seg_nxt = seg_of(w_disp_bcd_nxt[7:4]);
      2'd2: if (w_disp_bcd_nxt[11:8] != 4'd0) w_seg_nxt = seg_of(w_disp_bcd_nxt[11:8]);
      2'd3: if (w_disp_neg_nxt) w_seg_nxt = SEG_MINUS;
      default: w_seg_nxt = SEG_BLANK;
    endcase
  end

  // seg and dig registered together so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_dig <= 4'hF;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= ~(4'b0001 << r_idx);
    end
  end

  assign seg  = r_seg;
  assign dig  = r_dig;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_yqc_seg_scan.sv
// Self-checking bench for yqc_seg_scan with a fast scan divider.
module tb_yqc_seg_scan;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_neg = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  yqc_seg_scan #(.SCAN_DIV(SCAN_DIV), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_neg   (data_neg),
    .data_valid (data_valid),
    .seg        (seg),
    .dig        (dig),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rendering from decimal arithmetic on the displayed magnitude.
  function automatic logic [7:0] code(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int mag, input bit neg, input logic [3:0] d);
    case (d)
      4'hE: return code(mag % 10);
      4'hD: return (mag >= 10)  ? code((mag / 10) % 10) : 8'hFF;
      4'hB: return (mag >= 100) ? code(mag / 100) : 8'hFF;
      4'h7: return neg ? 8'hBF : 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  // Compare whatever digit is lit right now.
  task automatic check_lit(input string tag, input int mag, input bit neg);
    check(tag, {24'b0, seg}, {24'b0, exp_seg(mag, neg, dig)});
  endtask

  // Walk all four digits (bounded wait for each) and compare each pattern.
  task automatic check_display(input string tag, input int mag, input bit neg);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] target;
      int budget;
      target = ~(4'b0001 << k);
      budget = 0;
      while (dig !== target && budget < 4 * SCAN_DIV * 4) begin
        step();
        budget++;
      end
      if (dig !== target) check({tag, "_dig_timeout"}, {28'b0, dig}, {28'b0, target});
      else check_lit($sformatf("%s_d%0d", tag, k), mag, neg);
    end
  endtask

  task automatic pulse(input int v, input bit neg);
    data_in    = 8'(v);
    data_neg   = neg;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    while (busy !== 1'b0 && budget < 40) begin
      step();
      budget++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // 1. Reset state and scan order
    step();
    step();
    check("rst_seg",  {24'b0, seg},  32'hFF);
    check("rst_dig",  {28'b0, dig},  32'hF);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] dexp;
      step();
      dexp = ~(4'b0001 << (((n - 1) / SCAN_DIV) % 4));
      check($sformatf("scan_dig_%0d", n), {28'b0, dig}, {28'b0, dexp});
      check_lit($sformatf("scan_seg_%0d", n), 0, 1'b0);
    end

    // 2. Value 8: busy window and display
    pulse(8, 1'b0);
    check("busy_t", {31'b0, busy}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("busy_t%0d", i), {31'b0, busy}, 32'd1);
    end
    step();
    check("busy_t9", {31'b0, busy}, 32'd0);
    step();
    check_lit("v8_first", 8, 1'b0);
    check_display("v8", 8, 1'b0);

    // 3. Negative 255
    pulse(255, 1'b1);
    wait_idle("v255");
    check_display("v255n", 255, 1'b1);

    // 4. 100: interior zero is not blanked
    pulse(100, 1'b0);
    wait_idle("v100");
    check_display("v100", 100, 1'b0);

    // 5. 12 then 3 and 6 while busy: 6 replaces 3 in pending
    for (int c = 0; c <= 17; c++) begin
      data_in    = (c == 0) ? 8'd12 : (c == 2) ? 8'd3 : 8'd6;
      data_neg   = 1'b0;
      data_valid = (c == 0 || c == 2 || c == 4);
      step();
      data_valid = 1'b0;
      if (c >= 10) check_lit($sformatf("pend_12_t%0d", c), 12, 1'b0);
    end
    step();
    step();
    for (int c = 20; c < 36; c++) begin
      step();
      check_lit($sformatf("pend_6_t%0d", c), 6, 1'b0);
    end
    wait_idle("pend");

    // 6. Reset mid-conversion of 77
    pulse(77, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_seg",  {24'b0, seg},  32'hFF);
    check("mid_rst_dig",  {28'b0, dig},  32'hF);
    for (int i = 0; i < 30; i++) begin
      step();
      check_lit($sformatf("no77_%0d", i), 0, 1'b0);
    end
    check("no77_busy", {31'b0, busy}, 32'd0);

    // 7. Random values, sometimes with an overlapping strobe (last one wins)
    for (int r = 0; r < 20; r++) begin
      int v, v2, exp_v, off;
      bit ng, ng2, exp_n;
      v  = $urandom_range(0, 255);
      ng = 1'($urandom % 2);
      exp_v = v;
      exp_n = ng;
      pulse(v, ng);
      if ($urandom % 2 == 1) begin
        v2  = $urandom_range(0, 255);
        ng2 = 1'($urandom % 2);
        off = $urandom_range(1, 9);
        for (int c = 1; c <= off; c++) begin
          if (c == off) begin
            data_in    = 8'(v2);
            data_neg   = ng2;
            data_valid = 1'b1;
          end
          step();
          data_valid = 1'b0;
        end
        exp_v = v2;
        exp_n = ng2;
      end
      wait_idle($sformatf("rnd%0d", r));
      check_display($sformatf("rnd%0d", r), exp_v, exp_n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
